yutorina_bus_arbiter: RTL and testbench

- Round-robin arbiter for the shared yutorina chip bus.
- Sits inside yutorina_chip, between the bus masters (CPU IF stage, CPU MEM stage, DMA, debug) and the bus address/data mux.
- Grants bus ownership to one master at a time and holds it until the owner releases.
- Inserts one turnaround cycle between owners and drives the owner index that steers the master-side mux.

---
 rtl/yutorina_bus_arbiter.sv | 73 +++++++
 tb/tb_yutorina_bus_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/yutorina_bus_arbiter.sv
// yutorina_bus_arbiter: round-robin bus arbiter with one turnaround cycle between owners; optional hold timeout via YUTORINA_BUS_ARB_TIMEOUT_EN
module yutorina_bus_arbiter #(
  parameter int ID_W     = 2,
  parameter int HOLD_MAX = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2**ID_W-1:0]   req,
  output logic [2**ID_W-1:0]   grnt,
  output logic [ID_W-1:0]      owner,
  output logic                 busy,
  output logic                 tout
);
  localparam int MASTER_NUM = 2**ID_W;
  typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;
  state_t          state;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] win;
  logic            win_vld;
  logic            revoke;
  // first requester at or after ptr, ascending with wrap; descending scan lets the nearest one win
  always_comb begin
    win     = ptr;
    win_vld = 1'b0;
    for (int k = MASTER_NUM - 1; k >= 0; k--) begin
      if (req[ptr + ID_W'(k)]) begin
        win     = ptr + ID_W'(k);
        win_vld = 1'b1;
      end
    end
  end
`ifdef YUTORINA_BUS_ARB_TIMEOUT_EN
  logic [7:0] cnt;
  assign revoke = (state == OWN) && req[owner] && (cnt == 8'(HOLD_MAX - 1)) && |(req & ~grnt);
  // hold counter: zero outside OWN so it starts from zero on every grant, saturates at the limit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else if (state != OWN) cnt <= '0;
    else if (cnt != 8'(HOLD_MAX - 1)) cnt <= cnt + 8'd1;
  end
`else
  assign revoke = 1'b0;
`endif
  // ownership FSM: IDLE and TURN both arbitrate; OWN holds until release or forced revoke
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      grnt  <= '0;
      owner <= '0;
      busy  <= 1'b0;
      tout  <= 1'b0;
    end else begin
      tout <= 1'b0;
      if (state == OWN) begin
        if (!req[owner] || revoke) begin
          grnt  <= '0;
          busy  <= 1'b0;
          ptr   <= owner + ID_W'(1);
          tout  <= revoke;
          state <= TURN;
        end
      end else if (win_vld) begin
        grnt  <= MASTER_NUM'(1) << win;
        owner <= win;
        busy  <= 1'b1;
        state <= OWN;
      end else begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_yutorina_bus_arbiter.sv
// tb_yutorina_bus_arbiter: vector table, corner sequences and randomized model check for the bus arbiter
module tb_yutorina_bus_arbiter;
  localparam int N        = 4;
  localparam int HOLD_MAX = 16;
`ifdef YUTORINA_BUS_ARB_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif
  logic         clk;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] grnt;
  logic [1:0]   owner;
  logic         busy;
  logic         tout;
  int n_cmp;
  int n_fail;
  bit m_own;
  int m_owner;
  int m_ptr;
  int m_cnt;
  bit m_tout;
  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] grnt;
    int           owner;
    bit           busy;
  } vec_t;
  vec_t tbl[13];

  yutorina_bus_arbiter #(.ID_W(2), .HOLD_MAX(HOLD_MAX)) dut (
    .clk(clk), .rst(rst), .req(req), .grnt(grnt), .owner(owner), .busy(busy), .tout(tout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_own = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_tout = 0;
  endfunction

  // reference: rotate-priority pick from ptr; owner keeps bus until its req drops (or hold limit with competition)
  function automatic void model_edge(input logic [N-1:0] r);
    int w;
    bit comp;
    w = -1;
    m_tout = 0;
    for (int k = 0; k < N; k++)
      if (w < 0 && r[(m_ptr + k) % N]) w = (m_ptr + k) % N;
    if (m_own) begin
      comp = (r & ~(N'(1) << m_owner)) != 0;
      if (!r[m_owner] || (TMO && m_cnt >= HOLD_MAX - 1 && comp)) begin
        m_tout = r[m_owner];
        m_own  = 0;
        m_ptr  = (m_owner + 1) % N;
      end else if (m_cnt < HOLD_MAX - 1) begin
        m_cnt++;
      end
    end else if (w >= 0) begin
      m_own = 1; m_owner = w; m_cnt = 0;
    end
  endfunction

  task automatic check_model(input string tag);
    chk({tag, "_grnt"}, int'(grnt), m_own ? (1 << m_owner) : 0);
    chk({tag, "_owner"}, int'(owner), m_owner);
    chk({tag, "_busy"}, int'(busy), int'(m_own));
    chk({tag, "_tout"}, int'(tout), int'(m_tout));
  endtask

  task automatic step_raw(input logic [N-1:0] r);
    req = r;
    @(posedge clk);
    model_edge(r);
    @(negedge clk);
  endtask

  task automatic step(input string tag, input logic [N-1:0] r);
    step_raw(r);
    check_model(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int first_zero;
    int bad;
    int order[$];
    int exp_order[5];
    logic [N-1:0] prev;
    logic [N-1:0] r;
    int held;
    n_cmp = 0;
    n_fail = 0;
    exp_order = '{0, 1, 2, 3, 0};
    tbl[0]  = '{4'b0000, 4'b0000, 0, 1'b0};
    tbl[1]  = '{4'b0100, 4'b0100, 2, 1'b1};
    tbl[2]  = '{4'b0100, 4'b0100, 2, 1'b1};
    tbl[3]  = '{4'b0000, 4'b0000, 2, 1'b0};
    tbl[4]  = '{4'b0000, 4'b0000, 2, 1'b0};
    tbl[5]  = '{4'b1001, 4'b1000, 3, 1'b1};
    tbl[6]  = '{4'b0001, 4'b0000, 3, 1'b0};
    tbl[7]  = '{4'b0001, 4'b0001, 0, 1'b1};
    tbl[8]  = '{4'b0000, 4'b0000, 0, 1'b0};
    tbl[9]  = '{4'b0001, 4'b0001, 0, 1'b1};
    tbl[10] = '{4'b0011, 4'b0001, 0, 1'b1};
    tbl[11] = '{4'b0010, 4'b0000, 0, 1'b0};
    tbl[12] = '{4'b0010, 4'b0010, 1, 1'b1};
    do_reset();
    for (int i = 0; i < 10; i++) step("idle", 4'b0000);
    for (int i = 0; i < 13; i++) begin
      step_raw(tbl[i].req);
      chk($sformatf("tbl%0d_grnt", i), int'(grnt), int'(tbl[i].grnt));
      chk($sformatf("tbl%0d_owner", i), int'(owner), tbl[i].owner);
      chk($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].busy));
      chk($sformatf("tbl%0d_tout", i), int'(tout), 0);
    end
    #2 rst = 1'b1;
    #1;
    chk("async_rst_grnt", int'(grnt), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_owner", int'(owner), 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    prev = '0;
    held = 0;
    for (int i = 0; i < 40 && order.size() < 5; i++) begin
      r = 4'b1111;
      if (busy && held == 3) r[owner] = 1'b0;
      step("rr", r);
      if (grnt != 0 && prev == 0) order.push_back(int'(owner));
      chk("rr_no_direct_switch", int'(prev != 0 && grnt != 0 && grnt != prev), 0);
      held = (grnt != 0) ? held + 1 : 0;
      prev = grnt;
    end
    chk("rr_order_len", order.size(), 5);
    for (int i = 0; i < order.size() && i < 5; i++) chk($sformatf("rr_order%0d", i), order[i], exp_order[i]);
    do_reset();
    step("fair", 4'b0010);
    step("fair", 4'b1010);
    step("fair", 4'b1000);
    chk("fair_turn_grnt", int'(grnt), 0);
    step("fair", 4'b1010);
    chk("fair_m3_grnt", int'(grnt), 4'b1000);
    step("fair", 4'b1010);
    step("fair", 4'b0010);
    step("fair", 4'b0010);
    chk("fair_m1_back", int'(grnt), 4'b0010);
    do_reset();
    first_zero = -1;
    for (int i = 1; i <= 40; i++) begin
      step("tmo", 4'b0101);
      if (first_zero < 0 && i > 1 && grnt == 0) first_zero = i;
    end
    chk("timeout_edge", first_zero, TMO ? 17 : -1);
    do_reset();
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step("solo", 4'b0001);
      if (grnt != 4'b0001 || tout) bad++;
    end
    chk("solo_no_revoke", bad, 0);
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r = N'($urandom_range(0, 15));
      if (m_own && $urandom_range(0, 7) != 0) r[m_owner] = 1'b1;
      step("rand", r);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
